// File: rtl/instruction_fetcher.sv
// -----------------------------------------------------------------------------
// instruction_fetcher
//
// Front-end fetch unit. Keeps the program counter, issues one instruction-cache
// request at a time, redirects the PC on JAL and predicted-taken branches, and
// buffers fetched instructions (with their PC and predicted direction) in a
// small circular queue that the decoder drains. A ROB flush redirects the PC,
// empties the queue and discards the response of any in-flight cache request.
//
// Parameters
//   IQ_SIZE   instruction-queue depth (power of two, >= 2)
//   RESET_PC  PC value after reset
//
// Ports
//   clk_in               clock, rising edge
//   rst_in               asynchronous active-high reset
//   rdy_in               global enable; low freezes all state
//   if_to_ic_valid       cache request valid, held until the response
//   if_to_ic_PC          cache request address
//   ic_to_if_ready       one-cycle response pulse from the cache
//   ic_to_if_inst        instruction word returned with ic_to_if_ready
//   if_to_pr_PC          predictor lookup address (mirrors if_to_ic_PC)
//   pr_to_if_prediction  combinational taken prediction for if_to_pr_PC
//   if_to_dc_valid       queue head valid
//   if_to_dc_inst        queue head instruction
//   if_to_dc_PC          queue head PC
//   if_to_dc_pred        queue head predicted-taken bit
//   dc_to_if_ready       decoder accepts the head this cycle
//   rob_to_if_flush      redirect pulse from the ROB
//   rob_to_if_new_PC     redirect target
// -----------------------------------------------------------------------------
module instruction_fetcher #(
    parameter int          IQ_SIZE  = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic        if_to_ic_valid,
    output logic [31:0] if_to_ic_PC,
    input  logic        ic_to_if_ready,
    input  logic [31:0] ic_to_if_inst,

    output logic [31:0] if_to_pr_PC,
    input  logic        pr_to_if_prediction,

    output logic        if_to_dc_valid,
    output logic [31:0] if_to_dc_inst,
    output logic [31:0] if_to_dc_PC,
    output logic        if_to_dc_pred,
    input  logic        dc_to_if_ready,

    input  logic        rob_to_if_flush,
    input  logic [31:0] rob_to_if_new_PC
);

    localparam int PTR_W = $clog2(IQ_SIZE);

    localparam logic [PTR_W-1:0] PTR_ONE    = 1;
    localparam logic [PTR_W:0]   COUNT_ONE  = 1;
    localparam logic [PTR_W:0]   FULL_COUNT = IQ_SIZE[PTR_W:0];

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE,   // no request outstanding
        ST_WAIT,   // request outstanding, response will be queued
        ST_DROP    // request outstanding, response will be discarded
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    state_t      state;
    logic [31:0] pc;

    iq_entry_t        iq_mem [IQ_SIZE];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    // -------------------------------------------------------------------------
    // Decode of the returning instruction: next PC and predicted direction
    // -------------------------------------------------------------------------
    logic        is_jal;
    logic        is_branch;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] next_pc;
    logic        resp_pred;

    assign is_jal    = (ic_to_if_inst[6:0] == OPC_JAL);
    assign is_branch = (ic_to_if_inst[6:0] == OPC_BRANCH);

    assign j_imm = {{11{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[19:12],
                    ic_to_if_inst[20], ic_to_if_inst[30:21], 1'b0};
    assign b_imm = {{19{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[7],
                    ic_to_if_inst[30:25], ic_to_if_inst[11:8], 1'b0};

    // JALR is deliberately treated as sequential; its target is resolved later.
    assign resp_pred = is_branch & pr_to_if_prediction;

    always_comb begin
        // NOTE: every path of a combinational block must assign its outputs;
        // the default here keeps the mux from turning into a latch.
        next_pc = pc + 32'd4;
        if (is_jal) begin
            next_pc = pc + j_imm;
        end else if (resp_pred) begin
            next_pc = pc + b_imm;
        end
    end

    // -------------------------------------------------------------------------
    // Queue push/pop qualifiers. A flush overrides both.
    // -------------------------------------------------------------------------
    logic iq_empty;
    logic iq_has_room;
    logic push;
    logic pop;

    assign iq_empty    = (count == '0);
    assign iq_has_room = (count < FULL_COUNT);
    assign push        = (state == ST_WAIT) && ic_to_if_ready && !rob_to_if_flush;
    assign pop         = !iq_empty && dc_to_if_ready && !rob_to_if_flush;

    // -------------------------------------------------------------------------
    // Fetch FSM, PC and request outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            if_to_ic_valid <= 1'b0;
            if_to_ic_PC    <= RESET_PC;
        end else if (rdy_in) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            if (rob_to_if_flush) begin
                pc <= rob_to_if_new_PC;
            end

            case (state)
                ST_IDLE: begin
                    // The flush cycle itself issues nothing; the redirected PC
                    // is requested on the following edge.
                    if (!rob_to_if_flush && iq_has_room) begin
                        state          <= ST_WAIT;
                        if_to_ic_valid <= 1'b1;
                        if_to_ic_PC    <= pc;
                    end
                end

                ST_WAIT: begin
                    if (ic_to_if_ready) begin
                        state          <= ST_IDLE;
                        if_to_ic_valid <= 1'b0;
                        if (!rob_to_if_flush) begin
                            pc <= next_pc;
                        end
                    end else if (rob_to_if_flush) begin
                        // Cache still owes us a response for the old address;
                        // keep the request up and throw the answer away.
                        state <= ST_DROP;
                    end
                end

                ST_DROP: begin
                    // A further flush here only moves pc (handled above).
                    if (ic_to_if_ready) begin
                        state          <= ST_IDLE;
                        if_to_ic_valid <= 1'b0;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    if_to_ic_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_to_pr_PC = if_to_ic_PC;

    // -------------------------------------------------------------------------
    // Instruction queue
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: the storage is reset because the head entry drives the
            // decoder outputs directly, which must read as zero out of reset.
            for (int i = 0; i < IQ_SIZE; i++) begin
                iq_mem[i] <= '0;
            end
        end else if (rdy_in) begin
            if (rob_to_if_flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    iq_mem[tail] <= '{inst: ic_to_if_inst, pc: pc, pred: resp_pred};
                    tail         <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + COUNT_ONE;
                    2'b01:   count <= count - COUNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    assign if_to_dc_valid = !iq_empty;
    assign if_to_dc_inst  = iq_mem[head].inst;
    assign if_to_dc_PC    = iq_mem[head].pc;
    assign if_to_dc_pred  = iq_mem[head].pred;

endmodule

// File: tb/tb_instruction_fetcher.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetcher
//
// Directed bench for instruction_fetcher. A small cache model answers requests
// after a fixed latency from a sparse program image (unlisted words are NOPs);
// requests issued and entries popped by the decoder are logged and compared
// against hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_instruction_fetcher;

    localparam logic [31:0] NOP      = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] JAL_P100 = 32'h1000_006F;  // jal x0,+0x100

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_to_ic_valid;
    logic [31:0] if_to_ic_PC;
    logic        ic_to_if_ready;
    logic [31:0] ic_to_if_inst;
    logic [31:0] if_to_pr_PC;
    logic        pr_to_if_prediction;
    logic        if_to_dc_valid;
    logic [31:0] if_to_dc_inst;
    logic [31:0] if_to_dc_PC;
    logic        if_to_dc_pred;
    logic        dc_to_if_ready;
    logic        rob_to_if_flush;
    logic [31:0] rob_to_if_new_PC;

    instruction_fetcher #(.IQ_SIZE(8), .RESET_PC(32'h0)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .if_to_ic_valid      (if_to_ic_valid),
        .if_to_ic_PC         (if_to_ic_PC),
        .ic_to_if_ready      (ic_to_if_ready),
        .ic_to_if_inst       (ic_to_if_inst),
        .if_to_pr_PC         (if_to_pr_PC),
        .pr_to_if_prediction (pr_to_if_prediction),
        .if_to_dc_valid      (if_to_dc_valid),
        .if_to_dc_inst       (if_to_dc_inst),
        .if_to_dc_PC         (if_to_dc_PC),
        .if_to_dc_pred       (if_to_dc_pred),
        .dc_to_if_ready      (dc_to_if_ready),
        .rob_to_if_flush     (rob_to_if_flush),
        .rob_to_if_new_PC    (rob_to_if_new_PC)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] prog [logic [31:0]];
    logic [31:0] reqs[$];
    logic [31:0] pops_pc[$];
    logic        pops_pred[$];
    logic        prev_valid;
    bit          cache_auto;
    int          cache_latency;
    int          wait_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return NOP;
    endfunction

    // Advance one clock. Pops are logged from the settled pre-edge values;
    // request launches and the cache model act #1 after the edge.
    task automatic tick();
        if (rdy_in && if_to_dc_valid && dc_to_if_ready && !rob_to_if_flush) begin
            pops_pc.push_back(if_to_dc_PC);
            pops_pred.push_back(if_to_dc_pred);
        end
        @(posedge clk_in);
        #1;
        if (if_to_ic_valid && !prev_valid) reqs.push_back(if_to_ic_PC);
        prev_valid     = if_to_ic_valid;
        ic_to_if_ready = 1'b0;
        if (cache_auto && if_to_ic_valid) begin
            wait_cnt++;
            if (wait_cnt >= cache_latency) begin
                ic_to_if_ready = 1'b1;
                ic_to_if_inst  = mem_word(if_to_ic_PC);
                wait_cnt       = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic do_reset();
        rst_in              = 1'b1;
        rdy_in              = 1'b1;
        ic_to_if_ready      = 1'b0;
        ic_to_if_inst       = 32'h0;
        pr_to_if_prediction = 1'b0;
        dc_to_if_ready      = 1'b0;
        rob_to_if_flush     = 1'b0;
        rob_to_if_new_PC    = 32'h0;
        cache_auto          = 1'b0;
        cache_latency       = 2;
        wait_cnt            = 0;
        prev_valid          = 1'b0;
        prog.delete();
        reqs.delete();
        pops_pc.delete();
        pops_pred.delete();
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    task automatic run_until_reqs(input int n, input int budget, input string name);
        int cyc = 0;
        while (reqs.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (reqs.size() < n) begin
            n_fails++;
            $display("FAIL %s_req_timeout: got %0d requests, expected at least %0d", name, reqs.size(), n);
        end
    endtask

    task automatic run_until_pops(input int n, input int budget, input string name);
        int cyc = 0;
        while (pops_pc.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (pops_pc.size() < n) begin
            n_fails++;
            $display("FAIL %s_pop_timeout: got %0d pops, expected at least %0d", name, pops_pc.size(), n);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL reset_ic_valid: got %b expected 0", if_to_ic_valid); end
        n_checks++; if (if_to_ic_PC !== 32'h0) begin n_fails++; $display("FAIL reset_ic_pc: got %h expected 00000000", if_to_ic_PC); end
        n_checks++; if (if_to_dc_valid !== 1'b0) begin n_fails++; $display("FAIL reset_dc_valid: got %b expected 0", if_to_dc_valid); end
        n_checks++; if (if_to_dc_inst !== 32'h0) begin n_fails++; $display("FAIL reset_dc_inst: got %h expected 00000000", if_to_dc_inst); end
        n_checks++; if (if_to_dc_PC !== 32'h0) begin n_fails++; $display("FAIL reset_dc_pc: got %h expected 00000000", if_to_dc_PC); end
        n_checks++; if (if_to_dc_pred !== 1'b0) begin n_fails++; $display("FAIL reset_dc_pred: got %b expected 0", if_to_dc_pred); end
        // First edge out of reset issues the request for RESET_PC.
        tick();
        n_checks++; if (if_to_ic_valid !== 1'b1) begin n_fails++; $display("FAIL first_req_valid: got %b expected 1", if_to_ic_valid); end
        n_checks++; if (if_to_pr_PC !== 32'h0) begin n_fails++; $display("FAIL first_req_pr_pc: got %h expected 00000000", if_to_pr_PC); end
        // Asynchronous reset in the middle of a request abandons it immediately.
        rst_in = 1'b1;
        #2;
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL async_reset_valid: got %b expected 0", if_to_ic_valid); end
        rst_in = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        dc_to_if_ready = 1'b1;
        cache_auto     = 1'b1;
        run_until_reqs(6, 100, "seq");
        run_until_pops(5, 100, "seq");
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (reqs[i] !== 32'(4 * i)) begin n_fails++; $display("FAIL seq_req[%0d]: got %h expected %h", i, reqs[i], 32'(4 * i)); end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (pops_pc[i] !== 32'(4 * i)) begin n_fails++; $display("FAIL seq_pop_pc[%0d]: got %h expected %h", i, pops_pc[i], 32'(4 * i)); end
            n_checks++;
            if (pops_pred[i] !== 1'b0) begin n_fails++; $display("FAIL seq_pop_pred[%0d]: got %b expected 0", i, pops_pred[i]); end
        end
    endtask

    task automatic test_branch(input logic pred, input logic [31:0] exp_next, input string name);
        do_reset();
        prog[32'h10]        = BEQ_M8;
        pr_to_if_prediction = pred;
        dc_to_if_ready      = 1'b1;
        cache_auto          = 1'b1;
        run_until_reqs(6, 100, name);
        run_until_pops(5, 100, name);
        n_checks++; if (reqs[5] !== exp_next) begin n_fails++; $display("FAIL %s_next_req: got %h expected %h", name, reqs[5], exp_next); end
        n_checks++; if (pops_pc[4] !== 32'h10) begin n_fails++; $display("FAIL %s_pop_pc: got %h expected 00000010", name, pops_pc[4]); end
        n_checks++; if (pops_pred[4] !== pred) begin n_fails++; $display("FAIL %s_pop_pred: got %b expected %b", name, pops_pred[4], pred); end
        // A non-branch fetched while the predictor says taken still carries pred 0.
        n_checks++; if (pops_pred[3] !== 1'b0) begin n_fails++; $display("FAIL %s_nonbranch_pred: got %b expected 0", name, pops_pred[3]); end
    endtask

    task automatic test_jal();
        do_reset();
        prog[32'h20]        = JAL_P100;
        pr_to_if_prediction = 1'b1;
        dc_to_if_ready      = 1'b1;
        cache_auto          = 1'b1;
        run_until_reqs(10, 150, "jal");
        run_until_pops(9, 150, "jal");
        n_checks++; if (reqs[8] !== 32'h20) begin n_fails++; $display("FAIL jal_req_at: got %h expected 00000020", reqs[8]); end
        n_checks++; if (reqs[9] !== 32'h120) begin n_fails++; $display("FAIL jal_target: got %h expected 00000120", reqs[9]); end
        n_checks++; if (pops_pc[8] !== 32'h20) begin n_fails++; $display("FAIL jal_pop_pc: got %h expected 00000020", pops_pc[8]); end
        n_checks++; if (pops_pred[8] !== 1'b0) begin n_fails++; $display("FAIL jal_pop_pred: got %b expected 0", pops_pred[8]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_reqs [4];
        exp_reqs = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        do_reset();
        prog[32'h0]         = BEQ_M8;
        pr_to_if_prediction = 1'b1;
        dc_to_if_ready      = 1'b1;
        cache_auto          = 1'b1;
        run_until_reqs(4, 100, "wrap");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (reqs[i] !== exp_reqs[i]) begin n_fails++; $display("FAIL wrap_req[%0d]: got %h expected %h", i, reqs[i], exp_reqs[i]); end
        end
    endtask

    task automatic test_queue_full();
        do_reset();
        dc_to_if_ready = 1'b0;
        cache_auto     = 1'b1;
        repeat (60) tick();
        n_checks++; if (reqs.size() != 8) begin n_fails++; $display("FAIL full_req_count: got %0d expected 8", reqs.size()); end
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL full_ic_valid: got %b expected 0", if_to_ic_valid); end
        n_checks++; if (if_to_dc_valid !== 1'b1) begin n_fails++; $display("FAIL full_dc_valid: got %b expected 1", if_to_dc_valid); end
        n_checks++; if (if_to_dc_PC !== 32'h0) begin n_fails++; $display("FAIL full_head_pc: got %h expected 00000000", if_to_dc_PC); end
        // One pop frees one slot, which allows exactly one more request.
        dc_to_if_ready = 1'b1;
        tick();
        dc_to_if_ready = 1'b0;
        repeat (30) tick();
        n_checks++; if (reqs.size() != 9) begin n_fails++; $display("FAIL refill_req_count: got %0d expected 9", reqs.size()); end
        n_checks++; if (reqs[8] !== 32'h20) begin n_fails++; $display("FAIL refill_req_pc: got %h expected 00000020", reqs[8]); end
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL refill_ic_valid: got %b expected 0", if_to_ic_valid); end
        n_checks++; if (if_to_dc_PC !== 32'h4) begin n_fails++; $display("FAIL refill_head_pc: got %h expected 00000004", if_to_dc_PC); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        dc_to_if_ready = 1'b0;
        cache_auto     = 1'b1;
        run_until_reqs(3, 100, "flush_wait");
        cache_auto = 1'b0;
        n_checks++; if (if_to_dc_valid !== 1'b1) begin n_fails++; $display("FAIL fw_pre_dc_valid: got %b expected 1", if_to_dc_valid); end
        rob_to_if_flush  = 1'b1;
        rob_to_if_new_PC = 32'h400;
        tick();
        rob_to_if_flush  = 1'b0;
        n_checks++; if (if_to_dc_valid !== 1'b0) begin n_fails++; $display("FAIL fw_queue_empty: got %b expected 0", if_to_dc_valid); end
        n_checks++; if (if_to_ic_valid !== 1'b1) begin n_fails++; $display("FAIL fw_drop_valid: got %b expected 1", if_to_ic_valid); end
        n_checks++; if (if_to_ic_PC !== 32'h8) begin n_fails++; $display("FAIL fw_drop_pc: got %h expected 00000008", if_to_ic_PC); end
        tick();
        tick();
        ic_to_if_ready = 1'b1;
        ic_to_if_inst  = JAL_P100;
        tick();
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL fw_idle_valid: got %b expected 0", if_to_ic_valid); end
        n_checks++; if (if_to_dc_valid !== 1'b0) begin n_fails++; $display("FAIL fw_resp_dropped: got %b expected 0", if_to_dc_valid); end
        tick();
        n_checks++; if (if_to_ic_valid !== 1'b1) begin n_fails++; $display("FAIL fw_new_valid: got %b expected 1", if_to_ic_valid); end
        n_checks++; if (if_to_ic_PC !== 32'h400) begin n_fails++; $display("FAIL fw_new_pc: got %h expected 00000400", if_to_ic_PC); end
    endtask

    task automatic test_flush_collide();
        int cyc = 0;
        do_reset();
        prog[32'h8]    = JAL_P100;
        dc_to_if_ready = 1'b0;
        cache_auto     = 1'b1;
        run_until_reqs(3, 100, "collide");
        while (!ic_to_if_ready && cyc < 10) begin
            tick();
            cyc++;
        end
        n_checks++; if (ic_to_if_ready !== 1'b1) begin n_fails++; $display("FAIL fc_resp_timeout: got %b expected 1", ic_to_if_ready); end
        n_checks++; if (if_to_dc_valid !== 1'b1) begin n_fails++; $display("FAIL fc_pre_dc_valid: got %b expected 1", if_to_dc_valid); end
        rob_to_if_flush  = 1'b1;
        rob_to_if_new_PC = 32'h800;
        dc_to_if_ready   = 1'b1;
        tick();
        rob_to_if_flush  = 1'b0;
        dc_to_if_ready   = 1'b0;
        n_checks++; if (if_to_dc_valid !== 1'b0) begin n_fails++; $display("FAIL fc_queue_empty: got %b expected 0", if_to_dc_valid); end
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL fc_idle_valid: got %b expected 0", if_to_ic_valid); end
        tick();
        n_checks++; if (if_to_ic_valid !== 1'b1) begin n_fails++; $display("FAIL fc_new_valid: got %b expected 1", if_to_ic_valid); end
        n_checks++; if (if_to_ic_PC !== 32'h800) begin n_fails++; $display("FAIL fc_new_pc: got %h expected 00000800", if_to_ic_PC); end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        tick();
        rdy_in           = 1'b0;
        rob_to_if_flush  = 1'b1;
        rob_to_if_new_PC = 32'h40;
        dc_to_if_ready   = 1'b1;
        repeat (3) begin
            ic_to_if_ready = 1'b1;
            ic_to_if_inst  = JAL_P100;
            tick();
        end
        n_checks++; if (if_to_ic_valid !== 1'b1) begin n_fails++; $display("FAIL hold_valid: got %b expected 1", if_to_ic_valid); end
        n_checks++; if (if_to_ic_PC !== 32'h0) begin n_fails++; $display("FAIL hold_pc: got %h expected 00000000", if_to_ic_PC); end
        n_checks++; if (if_to_dc_valid !== 1'b0) begin n_fails++; $display("FAIL hold_dc_valid: got %b expected 0", if_to_dc_valid); end
        rdy_in          = 1'b1;
        rob_to_if_flush = 1'b0;
        dc_to_if_ready  = 1'b0;
        ic_to_if_ready  = 1'b1;
        ic_to_if_inst   = NOP;
        tick();
        n_checks++; if (if_to_ic_valid !== 1'b0) begin n_fails++; $display("FAIL resume_valid: got %b expected 0", if_to_ic_valid); end
        n_checks++; if (if_to_dc_valid !== 1'b1) begin n_fails++; $display("FAIL resume_dc_valid: got %b expected 1", if_to_dc_valid); end
        n_checks++; if (if_to_dc_inst !== NOP) begin n_fails++; $display("FAIL resume_dc_inst: got %h expected %h", if_to_dc_inst, NOP); end
        n_checks++; if (if_to_dc_PC !== 32'h0) begin n_fails++; $display("FAIL resume_dc_pc: got %h expected 00000000", if_to_dc_PC); end
        tick();
        n_checks++; if (if_to_ic_PC !== 32'h4) begin n_fails++; $display("FAIL resume_next_pc: got %h expected 00000004", if_to_ic_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch(1'b1, 32'h08, "br_taken");
        test_branch(1'b0, 32'h14, "br_not_taken");
        test_jal();
        test_wrap();
        test_queue_full();
        test_flush_wait();
        test_flush_collide();
        test_rdy_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
